dmem_bridge: RTL and testbench

//  Sits between the single-cycle core's data port (aluout/writedata/memwrite/memtoreg) and a variable-latency

---
 rtl/dmem_bridge_if.sv | 21 ++
 rtl/dmem_bridge.sv | 146 ++++++++++++++
 tb/tb_dmem_bridge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_if.sv
// RAM-side bus of the data-memory bridge: registered request/address/data out, ready/read data back.
interface dmem_bridge_if #(
    parameter int unsigned AW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// Bridges a single-cycle core data port to a variable-latency word RAM, stalling the core until done.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_bridge #(
    parameter int unsigned AW       = 16,
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        bus_err,
    output logic        misalign,
    dmem_bridge_if.master mem
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          zero_q, zero_d;
    logic          bus_err_q, bus_err_d;
    logic [7:0]    timer_q, timer_d;
    logic          acc;
    logic          unused_addr;

    assign acc         = memread | memwrite;
    assign unused_addr = ^addr;

`ifdef DMEM_MISALIGN_CHK_EN
    logic mis_q, mis_d;
    logic mis_addr;
    assign mis_addr = addr[1:0] != 2'b00;
    assign misalign = mis_q;
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            maddr_q   <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            zero_q    <= 1'b0;
            bus_err_q <= 1'b0;
            timer_q   <= '0;
`ifdef DMEM_MISALIGN_CHK_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            maddr_q   <= maddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            zero_q    <= zero_d;
            bus_err_q <= bus_err_d;
            timer_q   <= timer_d;
`ifdef DMEM_MISALIGN_CHK_EN
            mis_q     <= mis_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        maddr_d   = maddr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        zero_d    = zero_q;
        bus_err_d = 1'b0;
        timer_d   = timer_q;
        stall     = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
        mis_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (acc) begin
                    stall = 1'b1;
`ifdef DMEM_MISALIGN_CHK_EN
                    if (mis_addr) begin
                        // Trapped access never reaches the RAM; core sees a 1-cycle stall.
                        mis_d   = 1'b1;
                        zero_d  = 1'b1;
                        state_d = StDone;
                    end else begin
`else
                    begin
`endif
                        we_d    = memwrite;
                        maddr_d = addr[AW+1:2];
                        wdata_d = wdata;
                        // Read+write together acts as a write and returns zero.
                        zero_d  = memread & memwrite;
                        req_d   = 1'b1;
                        timer_d = '0;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                stall = 1'b1;
                if (mem.mem_ready) begin
                    req_d = 1'b0;
                    if (!we_q) rdata_d = mem.mem_rdata;
                    state_d = StDone;
                end else if (timer_q == TimerLast) begin
                    req_d     = 1'b0;
                    rdata_d   = ERR_DATA;
                    zero_d    = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign rdata         = (state_q == StDone && zero_q) ? 32'h0 : rdata_q;
    assign bus_err       = bus_err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: stores, loads, timeout, reset mid-access, misalign, read+write.
module tb_dmem_bridge;
    localparam int unsigned AW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        bus_err;
    logic        misalign;
    int          total = 0;
    int          bad = 0;
    int          n;

    dmem_bridge_if #(.AW(AW)) bus ();

    dmem_bridge #(
        .AW(AW),
        .TIMEOUT(15),
        .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memread(memread),
        .memwrite(memwrite),
        .addr(addr),
        .wdata(wdata),
        .rdata(rdata),
        .stall(stall),
        .bus_err(bus_err),
        .misalign(misalign),
        .mem(bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled well after the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        cyc(); cyc();
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        reset = 1'b0;

        // 1: idle
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_mem_req", 32'(bus.mem_req), 32'd0);
        end
        chk("idle_rdata", rdata, 32'h0);
        chk("idle_bus_err", 32'(bus_err), 32'd0);

        // 2: store, ready in second REQ cycle
        memwrite = 1'b1; addr = 32'h10; wdata = 32'h1234_5678; #1;
        chk("st_idle_stall", 32'(stall), 32'd1);
        cyc();
        chk("st_req", 32'(bus.mem_req), 32'd1);
        chk("st_we", 32'(bus.mem_we), 32'd1);
        chk("st_addr", 32'(bus.mem_addr), 32'd4);
        chk("st_wdata", bus.mem_wdata, 32'h1234_5678);
        chk("st_req1_stall", 32'(stall), 32'd1);
        cyc();
        bus.mem_ready = 1'b1; #1;
        chk("st_req2_stall", 32'(stall), 32'd1);
        cyc();
        bus.mem_ready = 1'b0;
        chk("st_done_stall", 32'(stall), 32'd0);
        chk("st_done_req", 32'(bus.mem_req), 32'd0);
        chk("st_done_bus_err", 32'(bus_err), 32'd0);
        memwrite = 1'b0;
        cyc();
        chk("st_after_stall", 32'(stall), 32'd0);

        // 3: load, ready in first REQ (ready while idle is ignored)
        memread = 1'b1; addr = 32'h10;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678; #1;
        chk("ld_idle_stall", 32'(stall), 32'd1);
        cyc();
        chk("ld_req", 32'(bus.mem_req), 32'd1);
        chk("ld_we", 32'(bus.mem_we), 32'd0);
        cyc();
        bus.mem_ready = 1'b0;
        chk("ld_done_stall", 32'(stall), 32'd0);
        chk("ld_rdata", rdata, 32'h1234_5678);
        memread = 1'b0;
        cyc();

        // 4: timeout
        memread = 1'b1; addr = 32'h20; #1;
        n = 0;
        while (stall && n < 40) begin
            n++;
            cyc();
        end
        chk("to_stall_cycles", 32'(n), 32'd16);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_rdata", rdata, 32'hDEADBEEF);
        chk("to_req", 32'(bus.mem_req), 32'd0);
        memread = 1'b0;
        cyc();
        chk("to_bus_err_pulse", 32'(bus_err), 32'd0);

        // 5: reset in REQ, then stray ready
        memread = 1'b1; addr = 32'h30;
        cyc();
        chk("rr_req", 32'(bus.mem_req), 32'd1);
        reset = 1'b1; memread = 1'b0;
        cyc();
        chk("rr_req_dropped", 32'(bus.mem_req), 32'd0);
        reset = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55;
        cyc();
        bus.mem_ready = 1'b0;
        chk("rr_stall", 32'(stall), 32'd0);
        chk("rr_req_idle", 32'(bus.mem_req), 32'd0);
        chk("rr_rdata", rdata, 32'h0);
        chk("rr_bus_err", 32'(bus_err), 32'd0);
        cyc();

        // 6: misaligned store
        memwrite = 1'b1; addr = 32'h13; wdata = 32'hA5A5_A5A5; #1;
        chk("mis_idle_stall", 32'(stall), 32'd1);
        cyc();
`ifdef DMEM_MISALIGN_CHK_EN
        chk("mis_done_stall", 32'(stall), 32'd0);
        chk("mis_flag", 32'(misalign), 32'd1);
        chk("mis_no_req", 32'(bus.mem_req), 32'd0);
        chk("mis_rdata", rdata, 32'h0);
        memwrite = 1'b0;
        cyc();
        chk("mis_pulse", 32'(misalign), 32'd0);
        chk("mis_no_req2", 32'(bus.mem_req), 32'd0);
`else
        chk("mis_req", 32'(bus.mem_req), 32'd1);
        chk("mis_addr", 32'(bus.mem_addr), 32'd4);
        chk("mis_flag_off", 32'(misalign), 32'd0);
        bus.mem_ready = 1'b1;
        cyc();
        bus.mem_ready = 1'b0; memwrite = 1'b0;
        chk("mis_done_stall", 32'(stall), 32'd0);
        cyc();
`endif

        // 7: load then read+write together (acts as write, returns zero)
        memread = 1'b1; addr = 32'h44;
        cyc();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        cyc();
        bus.mem_ready = 1'b0;
        chk("rw_pre_rdata", rdata, 32'hCAFE_F00D);
        memread = 1'b0;
        cyc();
        memread = 1'b1; memwrite = 1'b1; addr = 32'h40; wdata = 32'h77;
        cyc();
        chk("rw_we", 32'(bus.mem_we), 32'd1);
        chk("rw_addr", 32'(bus.mem_addr), 32'h10);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h99;
        cyc();
        bus.mem_ready = 1'b0;
        chk("rw_done_stall", 32'(stall), 32'd0);
        chk("rw_rdata", rdata, 32'h0);
        memread = 1'b0; memwrite = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
